// File: rtl/rgmii_rx_decoder.sv
// rgmii_rx_decoder
//   Rebuilds bytes from RGMII DDR samples and decodes RX_DV/RX_ER. Strips the
//   preamble and SFD, then presents frame bytes to the MAC as an AXI-Stream
//   master with no back-pressure.
//
//   Ports
//     clk, reset_n        buffered PHY rx clock; synchronous active-low reset
//     q1 / q2             rising / falling edge samples, {rx_ctl, rxd[3:0]}
//     link_speed          2'b10/2'b11 = 1000, 2'b01 = 100, 2'b00 = 10
//     m_rx_axis_*         tdata / tvalid / tlast / tuser (frame error on tlast)
//
//   Build option
//     RGMII_RX_10_100_EN  when defined, adds nibble assembly for 10/100 links.
//                         When undefined, everything is decoded as gigabit and
//                         link_speed is ignored.
module rgmii_rx_decoder #(
  parameter int MAX_FRAME_BYTES = 1522
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] q1,
  input  logic [4:0] q2,
  input  logic [1:0] link_speed,
  output logic [7:0] m_rx_axis_tdata,
  output logic       m_rx_axis_tvalid,
  output logic       m_rx_axis_tlast,
  output logic       m_rx_axis_tuser
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, FLUSH, DROP} state_t;

  localparam logic [10:0] MAX_CNT = 11'(MAX_FRAME_BYTES);

  state_t      state_q, state_d;
  logic [4:0]  in1_q, in2_q;
  logic [7:0]  hold_q, hold_d;
  logic        full_q, full_d;
  logic [10:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        tuser_q, tuser_d;

  logic       dv, er, slow, byte_vld;
  logic [7:0] byte_w;

  // Only link_speed[1] matters (and only in the 10/100 build).
  logic unused_speed;
  assign unused_speed = ^link_speed;

  assign dv = in1_q[4];
  assign er = in1_q[4] ^ in2_q[4];

`ifdef RGMII_RX_10_100_EN
  logic       slow_q, slow_d;
  logic       phase_q, phase_d;
  logic [3:0] lo_q, lo_d;

  // In IDLE the live speed drives assembly so the very first nibble pairs
  // correctly; from the first byte on, the latched speed is used.
  assign slow = (state_q == IDLE) ? ~link_speed[1] : slow_q;

  always_comb begin
    phase_d = dv & slow & ~phase_q;
    lo_d    = (dv & ~phase_q) ? in1_q[3:0] : lo_q;
  end

  assign byte_vld = dv & (~slow | phase_q);
  assign byte_w   = slow ? {in1_q[3:0], lo_q} : {in2_q[3:0], in1_q[3:0]};
`else
  assign slow     = 1'b0;
  assign byte_vld = dv;
  assign byte_w   = {in2_q[3:0], in1_q[3:0]};
`endif

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    full_d   = full_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    tdata_d  = 8'h00;
    tvalid_d = 1'b0;
    tlast_d  = 1'b0;
    tuser_d  = 1'b0;
`ifdef RGMII_RX_10_100_EN
    slow_d   = slow_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (byte_vld) begin
          state_d = (byte_w == 8'h55) ? PREAMBLE : DROP;
`ifdef RGMII_RX_10_100_EN
          slow_d  = slow;
`endif
        end
      end
      PREAMBLE: begin
        if (!dv) begin
          state_d = IDLE;
        end else if (byte_vld) begin
          if (byte_w == 8'hD5) begin
            state_d = PAYLOAD;
            cnt_d   = '0;
            err_d   = 1'b0;
            full_d  = 1'b0;
          end else if (byte_w != 8'h55) begin
            state_d = DROP;
          end
        end
      end
      PAYLOAD: begin
        if (er) err_d = 1'b1;
        if (!dv) begin
          if (full_q && slow) begin
            // Hold the final byte one extra cycle so 10/100 beats stay at
            // least two cycles apart.
            state_d = FLUSH;
          end else begin
            state_d  = IDLE;
            full_d   = 1'b0;
            tvalid_d = full_q;
            tdata_d  = full_q ? hold_q : 8'h00;
            tlast_d  = full_q;
            tuser_d  = full_q & err_d;
          end
        end else if (byte_vld) begin
          if (cnt_q == MAX_CNT) begin
            // Oversize: close the frame on the held byte and discard the rest.
            state_d  = DROP;
            full_d   = 1'b0;
            tvalid_d = 1'b1;
            tdata_d  = hold_q;
            tlast_d  = 1'b1;
            tuser_d  = 1'b1;
          end else begin
            tvalid_d = full_q;
            tdata_d  = full_q ? hold_q : 8'h00;
            hold_d   = byte_w;
            full_d   = 1'b1;
            if (cnt_q != 11'h7FF) cnt_d = cnt_q + 11'd1;
          end
        end
      end
      FLUSH: begin
        state_d  = IDLE;
        full_d   = 1'b0;
        tvalid_d = 1'b1;
        tdata_d  = hold_q;
        tlast_d  = 1'b1;
        tuser_d  = err_q;
      end
      DROP: begin
        if (!dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      in1_q    <= '0;
      in2_q    <= '0;
      hold_q   <= '0;
      full_q   <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      in1_q    <= q1;
      in2_q    <= q2;
      hold_q   <= hold_d;
      full_q   <= full_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
    end
  end

`ifdef RGMII_RX_10_100_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slow_q  <= 1'b0;
      phase_q <= 1'b0;
      lo_q    <= '0;
    end else begin
      slow_q  <= slow_d;
      phase_q <= phase_d;
      lo_q    <= lo_d;
    end
  end
`endif

  assign m_rx_axis_tdata  = tdata_q;
  assign m_rx_axis_tvalid = tvalid_q;
  assign m_rx_axis_tlast  = tlast_q;
  assign m_rx_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// Directed bench for rgmii_rx_decoder (MAX_FRAME_BYTES = 64 so the oversize
// path is reachable with short frames). Beats are collected by a monitor and
// checked against hand-computed expectations after each frame.
module tb_rgmii_rx_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] q1 = '0;
  logic [4:0] q2 = '0;
  logic [1:0] link_speed = 2'b10;
  logic [7:0] tdata;
  logic       tvalid, tlast, tuser;

  rgmii_rx_decoder #(.MAX_FRAME_BYTES(64)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .q1               (q1),
    .q2               (q2),
    .link_speed       (link_speed),
    .m_rx_axis_tdata  (tdata),
    .m_rx_axis_tvalid (tvalid),
    .m_rx_axis_tlast  (tlast),
    .m_rx_axis_tuser  (tuser)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
    int         cyc;
  } beat_t;

  beat_t beats[$];
  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tvalid) beats.push_back('{tdata, tlast, tuser, cyc});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One gigabit symbol per clock; er toggles q2[4] away from dv.
  task automatic drive(input logic dv, input logic er, input logic [7:0] b);
    @(negedge clk);
    q1 = {dv, b[3:0]};
    q2 = {dv ^ er, b[7:4]};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input int n, input int err_idx);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < n; i++) drive(1'b1, i == err_idx, 8'(i + 1));
    idle(8);
  endtask

  // Expect beats 1..n_exp, tlast on the last, tuser only on the last if exp_user.
  task automatic check_frame(input string tag, input int n_exp, input logic exp_user, input logic gig);
    chk({tag, ".nbeats"}, beats.size(), n_exp);
    for (int i = 0; i < beats.size() && i < n_exp; i++) begin
      chk({tag, ".data"}, beats[i].d, 32'(i + 1));
      chk({tag, ".last"}, beats[i].l, i == n_exp - 1);
      chk({tag, ".user"}, beats[i].u, exp_user && (i == n_exp - 1));
      if (gig && i > 0) chk({tag, ".gap"}, beats[i].cyc - beats[i-1].cyc, 1);
    end
    beats.delete();
  endtask

  initial begin
    int nlast;
    repeat (3) @(negedge clk);
    chk("rst.tvalid", tvalid, 0);
    chk("rst.tdata", tdata, 0);
    chk("rst.tlast", tlast, 0);
    chk("rst.tuser", tuser, 0);
    reset_n = 1'b1;
    idle(4);

    // Clean gigabit frame
    send_frame(64, -1);
    check_frame("gig", 64, 1'b0, 1'b1);

    // RX_ER during payload byte 10
    send_frame(64, 9);
    check_frame("er", 64, 1'b1, 1'b1);

    // Bad preamble, then a good frame
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h12);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 8'(i + 1));
    idle(6);
    chk("badpre.nbeats", beats.size(), 0);
    beats.delete();
    send_frame(64, -1);
    check_frame("afterbad", 64, 1'b0, 1'b1);

    // Oversize: 100 payload bytes against a 64-byte limit
    send_frame(100, -1);
    check_frame("over", 64, 1'b1, 1'b1);
    send_frame(10, -1);
    check_frame("afterover", 10, 1'b0, 1'b1);

    // Reset asserted for one cycle at payload byte 20
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 20) begin
        chk("midrst.tvalid", tvalid, 0);
        chk("midrst.tdata", tdata, 0);
        chk("midrst.tlast", tlast, 0);
        chk("midrst.tuser", tuser, 0);
        reset_n = 1'b1;
      end
      if (i == 19) reset_n = 1'b0;
      q1 = {1'b1, 4'(i + 1)};
      q2 = {1'b1, 4'((i + 1) >> 4)};
    end
    idle(8);
    nlast = 0;
    foreach (beats[i]) if (beats[i].l) nlast++;
    chk("midrst.notlast", nlast, 0);
    beats.delete();
    send_frame(64, -1);
    check_frame("afterrst", 64, 1'b0, 1'b1);

`ifdef RGMII_RX_10_100_EN
    // 100 Mb/s: nibbles on q1 only, low nibble first
    link_speed = 2'b01;
    begin
      logic [3:0] nib [20];
      for (int i = 0; i < 15; i++) nib[i] = 4'h5;
      nib[15] = 4'hD; nib[16] = 4'h5; nib[17] = 4'hA; nib[18] = 4'hC; nib[19] = 4'h3;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        q1 = {1'b1, nib[i]};
        q2 = {1'b1, 4'h0};
      end
    end
    idle(8);
    chk("slow.nbeats", beats.size(), 2);
    if (beats.size() == 2) begin
      chk("slow.d0", beats[0].d, 8'hA5);
      chk("slow.l0", beats[0].l, 0);
      chk("slow.d1", beats[1].d, 8'h3C);
      chk("slow.l1", beats[1].l, 1);
      chk("slow.u1", beats[1].u, 0);
      chk("slow.gap", 32'(beats[1].cyc - beats[0].cyc >= 2), 1);
    end
    beats.delete();
    link_speed = 2'b10;
`else
    // Without 10/100 support link_speed is ignored
    link_speed = 2'b01;
    send_frame(16, -1);
    check_frame("spdign", 16, 1'b0, 1'b1);
    link_speed = 2'b10;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
